// File: rtl/chess_clock_pkg.sv
// Shared types and constants for the two-player chess clock controller.
// Times are carried as packed {min, sec} so they map directly onto the 9-bit display ports.
package chess_clock_pkg;

    localparam int MIN_W   = 3;
    localparam int SEC_W   = 6;
    localparam int SEC_MAX = 59;

    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN_W = 3'd1,
        RUN_B = 3'd2,
        PAUSE = 3'd3,
        FLAG  = 3'd4
    } state_t;

    typedef struct packed {
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
    } clock_time_t;

    function automatic clock_time_t make_time(input int minutes, input int seconds);
        clock_time_t t;
        t.min = MIN_W'(minutes);
        t.sec = SEC_W'(seconds);
        return t;
    endfunction

endpackage

// File: rtl/side_clock.sv
// One player's mm:ss countdown register with load, borrow-aware decrement and,
// when INCREMENT_EN is defined, a saturating per-move increment.
module side_clock
    import chess_clock_pkg::*;
#(
    parameter int START_MIN = 5,
    parameter int START_SEC = 0
`ifdef INCREMENT_EN
    ,
    parameter int INC_SEC   = 0
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [8:0] load_value,
`ifdef INCREMENT_EN
    input  logic       inc,
`endif
    input  logic       dec,
    output logic [8:0] value,
    output logic       zero
);

    clock_time_t cur;

`ifdef INCREMENT_EN
    localparam logic [SEC_W:0] INC_STEP  = (SEC_W+1)'(INC_SEC);
    localparam logic [SEC_W:0] SEC_LIMIT = (SEC_W+1)'(SEC_MAX);
    localparam logic [SEC_W:0] SEC_WRAP  = (SEC_W+1)'(SEC_MAX + 1);

    logic [SEC_W:0] sec_sum;
    logic [SEC_W:0] sec_wrapped;
    clock_time_t    inc_time;

    // Seconds overflow carries into minutes; the top of the range pins at 7:59.
    always_comb begin
        sec_sum     = {1'b0, cur.sec} + INC_STEP;
        sec_wrapped = sec_sum - SEC_WRAP;
        inc_time    = cur;
        if (sec_sum > SEC_LIMIT) begin
            if (cur.min == '1) begin
                inc_time.sec = SEC_W'(SEC_MAX);
            end else begin
                inc_time.min = cur.min + 1'b1;
                inc_time.sec = sec_wrapped[SEC_W-1:0];
            end
        end else begin
            inc_time.sec = sec_sum[SEC_W-1:0];
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= make_time(START_MIN, START_SEC);
        end else if (load) begin
            cur <= load_value;
`ifdef INCREMENT_EN
        end else if (inc) begin
            cur <= inc_time;
`endif
        end else if (dec && !zero) begin
            if (cur.sec != '0) begin
                cur.sec <= cur.sec - 1'b1;
            end else begin
                cur.min <= cur.min - 1'b1;
                cur.sec <= SEC_W'(SEC_MAX);
            end
        end
    end

    assign value = cur;
    assign zero  = (cur == '0);

endmodule

// File: rtl/chess_clock_ctrl.sv
// Chess clock game sequencer: 1 s divider, game FSM and move handshake driving two side_clock timers.
// Define INCREMENT_EN to credit INC_SEC to the mover's clock on every accepted move.
module chess_clock_ctrl
    import chess_clock_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int START_MIN = 5,
    parameter int START_SEC = 0,
    parameter int INC_SEC   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       move_valid,
    input  logic       move_color,
    output logic       move_ready,
    output logic [8:0] time_white,
    output logic [8:0] time_black,
    output logic       side,
    output logic [2:0] state,
    output logic       tick,
    output logic       flag,
    output logic       flag_side
);

    localparam int DIV_W = $clog2(CLK_HZ);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_HZ - 1);
    localparam logic [8:0]       START_TIME = make_time(START_MIN, START_SEC);

    if (CLK_HZ < 2 || START_MIN < 0 || START_MIN > 7 || START_SEC < 0 || START_SEC > SEC_MAX ||
        INC_SEC < 0 || INC_SEC > SEC_MAX) begin : g_bad_params
        $error("chess_clock_ctrl: parameter out of range");
    end

    state_t           state_q, state_d;
    logic [DIV_W-1:0] divider;
    logic             saved_side;
    logic             running, restart, move_accept, wrap, tick_event, expiring;
    logic             zero_white, zero_black, run_zero;
    logic [8:0]       run_time;

    assign running     = (state_q == RUN_W) || (state_q == RUN_B);
    assign restart     = ((state_q == IDLE) || (state_q == FLAG)) && start;
    assign move_accept = move_valid && move_ready;
    assign wrap        = running && (divider == DIV_LAST);
    // A move landing on the wrap cycle swallows that second's decrement.
    assign tick_event  = wrap && !move_accept;
    assign run_zero    = side ? zero_black : zero_white;
    assign run_time    = side ? time_black : time_white;
    assign expiring    = tick_event && (run_zero || (run_time == 9'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, FLAG: if (start) state_d = RUN_W;
            RUN_W, RUN_B: begin
                if (move_accept)   state_d = pause ? PAUSE : (side ? RUN_W : RUN_B);
                else if (expiring) state_d = FLAG;
                else if (pause)    state_d = PAUSE;
            end
            PAUSE: if (pause) state_d = saved_side ? RUN_B : RUN_W;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        move_ready = running && (move_color == side);
    end

    // Divider, side bookkeeping and status flags; the divider freezes outside the RUN states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divider    <= '0;
            side       <= WHITE;
            saved_side <= WHITE;
            flag       <= 1'b0;
            flag_side  <= WHITE;
            tick       <= 1'b0;
        end else begin
            tick <= tick_event && !run_zero;
            if (restart) begin
                divider <= '0;
                side    <= WHITE;
                flag    <= 1'b0;
            end else if (running) begin
                divider <= (move_accept || wrap) ? '0 : divider + 1'b1;
                if (move_accept) side <= ~side;
                if (state_d == PAUSE) saved_side <= move_accept ? ~side : side;
                if (state_d == FLAG) begin
                    flag      <= 1'b1;
                    flag_side <= side;
                end
            end
        end
    end

    assign state = state_q;

    side_clock #(
        .START_MIN(START_MIN),
        .START_SEC(START_SEC)
`ifdef INCREMENT_EN
        ,
        .INC_SEC  (INC_SEC)
`endif
    ) u_white (
        .clk       (clk),
        .rst       (rst),
        .load      (restart),
        .load_value(START_TIME),
`ifdef INCREMENT_EN
        .inc       (move_accept && (side == WHITE)),
`endif
        .dec       (tick_event && (side == WHITE)),
        .value     (time_white),
        .zero      (zero_white)
    );

    side_clock #(
        .START_MIN(START_MIN),
        .START_SEC(START_SEC)
`ifdef INCREMENT_EN
        ,
        .INC_SEC  (INC_SEC)
`endif
    ) u_black (
        .clk       (clk),
        .rst       (rst),
        .load      (restart),
        .load_value(START_TIME),
`ifdef INCREMENT_EN
        .inc       (move_accept && (side == BLACK)),
`endif
        .dec       (tick_event && (side == BLACK)),
        .value     (time_black),
        .zero      (zero_black)
    );

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Self-checking bench for chess_clock_ctrl: vector table, directed game sequences and a
// randomized run against a seconds-based reference model (honours INCREMENT_EN).
module tb_chess_clock_ctrl;

    localparam int CLK_HZ    = 4;
    localparam int START_MIN = 5;
    localparam int START_SEC = 0;
    localparam int INC_SEC   = 5;
    localparam int START_T   = START_MIN * 60 + START_SEC;
    localparam int MAX_T     = 7 * 60 + 59;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, pause, move_valid, move_color;
    logic       move_ready, side, tick, flag, flag_side;
    logic [8:0] time_white, time_black;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    chess_clock_ctrl #(
        .CLK_HZ   (CLK_HZ),
        .START_MIN(START_MIN),
        .START_SEC(START_SEC),
        .INC_SEC  (INC_SEC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .move_valid(move_valid),
        .move_color(move_color),
        .move_ready(move_ready),
        .time_white(time_white),
        .time_black(time_black),
        .side      (side),
        .state     (state),
        .tick      (tick),
        .flag      (flag),
        .flag_side (flag_side)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       pause;
        logic       mv;
        logic       mc;
        logic       exp_ready;
        logic [2:0] exp_state;
        logic       exp_side;
    } vec_t;

    vec_t vecs[13];

    // Reference model: remaining time held as plain seconds per player.
    int   m_mode;          // 0 idle, 1 running, 2 paused, 3 flag fallen
    int   m_w, m_b, m_div;
    logic m_side, m_saved, m_flag, m_fside, m_tick;

    function automatic logic [8:0] enc(input int t);
        return {3'(t / 60), 6'(t % 60)};
    endfunction

    function automatic int incExp(input int t);
`ifdef INCREMENT_EN
        return (t + INC_SEC > MAX_T) ? MAX_T : t + INC_SEC;
`else
        return t;
`endif
    endfunction

    function automatic logic [2:0] modelStateCode();
        case (m_mode)
            1:       return m_side ? 3'd2 : 3'd1;
            2:       return 3'd3;
            3:       return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic modelReady(input logic mc);
        return (m_mode == 1) && (mc == m_side);
    endfunction

    task automatic modelReset();
        m_mode = 0; m_w = START_T; m_b = START_T; m_div = 0;
        m_side = 1'b0; m_saved = 1'b0; m_flag = 1'b0; m_fside = 1'b0; m_tick = 1'b0;
    endtask

    task automatic modelStep(input logic s, input logic p, input logic mv, input logic mc);
        logic accepted;
        logic wrapped;
        accepted = mv && modelReady(mc);
        m_tick = 1'b0;
        if (m_mode == 0 || m_mode == 3) begin
            if (s) begin
                m_w = START_T; m_b = START_T; m_flag = 1'b0; m_div = 0; m_side = 1'b0; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (accepted) begin
                if (m_side) m_b = incExp(m_b);
                else        m_w = incExp(m_w);
                m_side = ~m_side;
                m_div = 0;
                if (p) begin m_mode = 2; m_saved = m_side; end
            end else begin
                wrapped = (m_div == CLK_HZ - 1);
                m_div = wrapped ? 0 : m_div + 1;
                if (wrapped) begin
                    if (!m_side && m_w > 0) begin m_w--; m_tick = 1'b1; end
                    if (m_side && m_b > 0)  begin m_b--; m_tick = 1'b1; end
                    if ((m_side ? m_b : m_w) == 0) begin
                        m_mode = 3; m_flag = 1'b1; m_fside = m_side;
                    end
                end
                if (m_mode == 1 && p) begin m_mode = 2; m_saved = m_side; end
            end
        end else if (m_mode == 2) begin
            if (p) begin m_mode = 1; m_side = m_saved; end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic mv, input logic mc);
        start = s; pause = p; move_valid = mv; move_color = mc;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int ticks;
        int w1;
        logic s, p, mv, mc;

        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};

        // Reset values
        doReset();
        #1;
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_side", 32'(side), 32'd0);
        checkOutput("reset_flag", 32'({flag, flag_side, tick}), 32'd0);
        checkOutput("reset_move_ready", 32'(move_ready), 32'd0);
        checkOutput("reset_time_white", 32'(time_white), 32'(enc(START_T)));
        checkOutput("reset_time_black", 32'(time_black), 32'(enc(START_T)));

        // Vector table: handshake gating, ignored start/pause, pause/resume, move+pause
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].start, vecs[i].pause, vecs[i].mv, vecs[i].mc);
            #1;
            checkOutput($sformatf("vec%0d_ready", i), 32'(move_ready), 32'(vecs[i].exp_ready));
            stepClock();
            checkOutput($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
            checkOutput($sformatf("vec%0d_side", i), 32'(side), 32'(vecs[i].exp_side));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Start then 16 cycles: four decrements of white only
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        ticks = 0;
        for (int i = 0; i < 16; i++) begin
            stepClock();
            if (tick === 1'b1) ticks++;
        end
        checkOutput("start_tick_count", 32'(ticks), 32'd4);
        checkOutput("start_time_white", 32'(time_white), 32'(enc(START_T - 4)));
        checkOutput("start_time_black", 32'(time_black), 32'(enc(START_T)));
        checkOutput("start_state", 32'(state), 32'd1);

        // Handshake: wrong colour refused, right colour switches side; black borrows 5:00 -> 4:59
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("hs_wrong_ready", 32'(move_ready), 32'd0);
        stepClock();
        checkOutput("hs_wrong_state", 32'({state, side}), 32'({3'd1, 1'b0}));
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("hs_right_ready", 32'(move_ready), 32'd1);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("hs_right_state", 32'({state, side}), 32'({3'd2, 1'b1}));
        repeat (3) stepClock();
        checkOutput("hs_black_hold", 32'(time_black), 32'(enc(START_T)));
        stepClock();
        w1 = incExp(START_T - 4);
        checkOutput("hs_black_borrow", 32'(time_black), 32'(enc(START_T - 1)));
        checkOutput("hs_black_tick", 32'(tick), 32'd1);
        checkOutput("hs_white_after_move", 32'(time_white), 32'(enc(w1)));

        // Pause at divider=2, frozen for 40 cycles, resume decrements after 2 cycles
        repeat (2) stepClock();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pause_state", 32'(state), 32'd3);
        repeat (40) stepClock();
        checkOutput("pause_frozen", 32'({time_white, time_black}), 32'({enc(w1), enc(START_T - 1)}));
        checkOutput("pause_still", 32'(state), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("resume_state", 32'(state), 32'd2);
        checkOutput("resume_hold", 32'(time_black), 32'(enc(START_T - 1)));
        stepClock();
        checkOutput("resume_decrement", 32'(time_black), 32'(enc(START_T - 2)));

        // Move on the wrap cycle: no decrement, side toggles; then with pause as well
        repeat (3) stepClock();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("coll_state", 32'({state, side}), 32'({3'd1, 1'b0}));
        checkOutput("coll_black", 32'(time_black), 32'(enc(incExp(START_T - 2))));
        checkOutput("coll_no_tick", 32'(tick), 32'd0);
        repeat (3) stepClock();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("coll_pause_state", 32'({state, side}), 32'({3'd3, 1'b1}));
        checkOutput("coll_pause_white", 32'(time_white), 32'(enc(incExp(w1))));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("coll_resume", 32'(state), 32'd2);

        // White runs out: 0:59 borrow on the way, FLAG exactly 300 seconds in, then restart
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (state !== 3'd4 && n < 1300) begin
            stepClock();
            n++;
            if (n == 964) checkOutput("flag_borrow_059", 32'(time_white), 32'(enc(59)));
        end
        checkOutput("flag_latency", 32'(n), 32'(START_T * CLK_HZ));
        checkOutput("flag_status", 32'({flag, flag_side}), 32'({1'b1, 1'b0}));
        checkOutput("flag_white_zero", 32'(time_white), 32'd0);
        checkOutput("flag_black", 32'(time_black), 32'(enc(START_T)));
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("flag_ready", 32'(move_ready), 32'd0);
        repeat (10) stepClock();
        checkOutput("flag_hold", 32'({state, flag, time_white}), 32'({3'd4, 1'b1, 9'd0}));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("restart", 32'({state, flag, time_white}), 32'({3'd1, 1'b0, enc(START_T)}));

        // Asynchronous reset mid-cycle
        repeat (6) stepClock();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", 32'({state, side, time_white}), 32'({3'd0, 1'b0, enc(START_T)}));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized play against the reference model
        modelReset();
        for (int i = 0; i < 5000; i++) begin
            checkOutput("random_regs",
                32'({state, side, time_white, time_black, flag, flag_side, tick}),
                32'({modelStateCode(), m_side, enc(m_w), enc(m_b), m_flag, m_fside, m_tick}));
            s  = ($urandom % 40) == 0;
            p  = ($urandom % 24) == 0;
            mv = ($urandom % 3) == 0;
            mc = 1'($urandom);
            applyStimulus(s, p, mv, mc);
            #1;
            checkOutput("random_ready", 32'(move_ready), 32'(modelReady(mc)));
            modelStep(s, p, mv, mc);
            stepClock();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chess_clock_ctrl.md
# chess_clock_ctrl

Game-sequencing controller for the two-player chess clock. It owns the per-side mm:ss countdowns and generates the 1 s tick from the system clock. It runs the game state machine (idle, running per side, paused, flag fallen) and accepts committed moves from the move logic through a valid/ready handshake to switch the running side. It sits between the board/move-validation logic and the display driver.

## Interface
- CLK_HZ, 100_000_000, clk cycles per second tick; minimum 2
- START_MIN, 5, initial minutes per side, 0..7
- START_SEC, 0, initial seconds per side, 0..59
- INC_SEC, 0, per-move increment seconds, 0..59; used only with increment compiled in
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  pulse; begins or restarts a game from IDLE or FLAG
- pause  in  1  pulse; toggles pause while a game is running or paused
- move_valid  in  1  move committed by move logic
- move_color  in  1  colour of the mover; 0 white, 1 black
- move_ready  out  1  high when a move with the current move_color is accepted
- time_white  out  9  {min[2:0], sec[5:0]} remaining for white
- time_black  out  9  {min[2:0], sec[5:0]} remaining for black
- side  out  1  side to move; 0 white, 1 black
- state  out  3  FSM state encoding
- tick  out  1  one-cycle strobe, one cycle after each applied decrement
- flag  out  1  a clock reached 00:00
- flag_side  out  1  side whose clock reached 00:00

## Operation
- States and encodings: IDLE=0, RUN_W=1, RUN_B=2, PAUSE=3, FLAG=4.
- Reset values:
  - state IDLE, side 0, flag 0, flag_side 0, tick 0, move_ready 0.
  - Both times {START_MIN, START_SEC}.
  - Divider 0, saved side 0.
- IDLE/FLAG + start: reload both times, clear flag and divider, go to RUN_W.
- start in RUN_W, RUN_B or PAUSE is ignored.
- move_ready = (state is RUN_W or RUN_B) && (move_color == side). It is combinational from state, side and move_color only.
- A move is accepted when move_valid && move_ready:
  - side toggles and state goes to the other RUN state.
  - The divider is cleared.
- Divider behaviour:
  - Counts 0..CLK_HZ-1 only in RUN states.
  - Holds its value in PAUSE.
  - Wraps to 0 at CLK_HZ-1; the wrap is the tick event.
- Tick event in a RUN state decrements the running side only:
  - If sec>0, sec-1.
  - Otherwise min-1 and sec=59.
- A decrement producing 00:00 moves the FSM to FLAG on the same edge. flag=1 and flag_side=side.
- Clocks never underflow.
- Tick and accepted move in the same cycle: the move wins and the tick is discarded (no decrement).
- pause in a RUN state: save side, go to PAUSE.
- pause in PAUSE: return to the RUN state of the saved side.
- pause and an accepted move in the same cycle: side toggles, then enter PAUSE with the new side saved.
- pause in IDLE or FLAG is ignored.
- FLAG: times, side and flag hold until start or rst.

## Timing
- All outputs except move_ready are registered.
- Decrement latency: the divider reaches CLK_HZ-1 in cycle n. Time updates at the edge ending cycle n, and tick is high in cycle n+1.
- Move latency: accepted in cycle n; side and state reflect it in cycle n+1.
- In RUN_W, the first decrement after start or after an accepted move occurs CLK_HZ cycles after that event.
- rst mid-operation returns immediately to the reset values. Any in-flight move is lost.

## Configuration
- INCREMENT_EN: on an accepted move, add INC_SEC to the mover's clock before switching side.
  - Carry sec>59 into minutes.
  - Saturate at 7:59.
- Without INCREMENT_EN: no increment logic is built and INC_SEC is ignored.

## Structure
- Package chess_clock_pkg holds:
  - State enum and encodings.
  - MIN_W=3, SEC_W=6, SEC_MAX=59.
  - Colour constants WHITE=0, BLACK=1.
  - Time struct {min, sec}.
- Sub-module side_clock is instantiated twice (white, black). It provides:
  - Inputs: load value, dec, inc (under INCREMENT_EN).
  - Output: zero flag.
  - It holds one mm:ss register.
- The FSM, divider and handshake stay in chess_clock_ctrl.

## Test plan
- Reset/start: CLK_HZ=4. rst, start, 16 cycles -> time_white=4:56, time_black=5:00, state=1, four tick strobes.
- Handshake: in RUN_W, move_valid with move_color=1 -> move_ready=0, no change. move_color=0 -> side=1 and state=2 next cycle. Black decrements CLK_HZ cycles later.
- Borrow and flag: START_MIN=1, START_SEC=0:
  - 1 tick -> 0:59.
  - START_MIN=0, START_SEC=3, 3 ticks -> state=4, flag=1, flag_side=0. Further cycles leave time at 0:00 and move_ready=0.
- Pause: pause at divider=2, hold 40 cycles -> times frozen. Second pause -> resume; next decrement after 2 more cycles.
- Collision: tick cycle coincides with accepted move -> no decrement of the mover, side toggles. Add pause the same cycle -> state=3, resume yields RUN_B.
- INCREMENT_EN, INC_SEC=5: white at 4:58 moves -> 5:03. At 7:57 moves -> 7:59.
